// File: rtl/garage_pkg.sv
// Shared constants and button FSM encoding for the garage input conditioner.
// Latency: none (types and constants only).
// Backpressure: none.
package garage_pkg;

  // Default number of consecutive stable clocks before a new level is accepted.
  localparam int DB_CYCLES_DEF = 16;

  // Button tracking state; encoding is fixed so RELEASED is the reset value.
  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } btn_state_e;

endpackage

// File: rtl/input_debouncer.sv
// One input channel: 2-flop synchronizer, then a run counter and a stable level.
// Latency: a clean raw edge reaches level_o 2 + DB_CYCLES edges after it is first sampled.
// Backpressure: none; free-running every clock.
module input_debouncer
  import garage_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o
);

  // The level flips on the edge where the count would have reached DB_CYCLES,
  // so the counter never actually holds DB_CYCLES and cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-stage synchronizer for the asynchronous raw input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing samples; any agreement restarts the run.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stable level and run counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/garage_input_conditioner.sv
// Debounces button and limit switches; emits one Activate pulse per press and a limit fault flag.
// Latency: limits 2 + DB_CYCLES edges; Activate and Lim_fault one further edge.
// Backpressure: none; outputs are levels/pulses with no handshake.
module garage_input_conditioner
  import garage_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic Btn_raw,
  input  logic Up_lim_raw,
  input  logic Dn_lim_raw,
  output logic Activate,
  output logic Up_max,
  output logic Dn_max,
  output logic Lim_fault
);

  logic       btn_db;
  logic       up_db;
  logic       dn_db;
  btn_state_e state_q;
  btn_state_e state_d;
  logic       activate_q;
  logic       activate_d;
  logic       lim_fault_q;

  input_debouncer #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_btn_db (
    .clk_i   (CLK),
    .rst_ni  (RST_n),
    .raw_i   (Btn_raw),
    .level_o (btn_db)
  );

  input_debouncer #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_up_db (
    .clk_i   (CLK),
    .rst_ni  (RST_n),
    .raw_i   (Up_lim_raw),
    .level_o (up_db)
  );

  input_debouncer #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_dn_db (
    .clk_i   (CLK),
    .rst_ni  (RST_n),
    .raw_i   (Dn_lim_raw),
    .level_o (dn_db)
  );

  // Button FSM: fire Activate only on the RELEASED->PRESSED step, so a hold gives one pulse.
  always_comb begin
    state_d    = state_q;
    activate_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (btn_db) begin
          state_d    = PRESSED;
          activate_d = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_db) begin
          state_d = RELEASED;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // FSM state, registered Activate pulse and registered limit fault.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= RELEASED;
      activate_q  <= 1'b0;
      lim_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      activate_q  <= activate_d;
      lim_fault_q <= up_db & dn_db;
    end
  end

  // Limits are passed straight from the debouncer registers, even during a fault.
  assign Up_max    = up_db;
  assign Dn_max    = dn_db;
  assign Activate  = activate_q;
  assign Lim_fault = lim_fault_q;

endmodule

// File: tb/tb_garage_input_conditioner.sv
// Scoreboard bench for garage_input_conditioner with DB_CYCLES=4 and a 20 ns clock.
// Expectations come from a sample-window reference model, one entry per rising edge.
// A monitor pops and compares every edge independently of the stimulus.
module tb_garage_input_conditioner;

  localparam int DB = 4;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  logic Btn_raw = 1'b0;
  logic Up_lim_raw = 1'b0;
  logic Dn_lim_raw = 1'b0;
  logic Activate;
  logic Up_max;
  logic Dn_max;
  logic Lim_fault;

  garage_input_conditioner #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .Btn_raw    (Btn_raw),
    .Up_lim_raw (Up_lim_raw),
    .Dn_lim_raw (Dn_lim_raw),
    .Activate   (Activate),
    .Up_max     (Up_max),
    .Dn_max     (Dn_max),
    .Lim_fault  (Lim_fault)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic act;
    logic up;
    logic dn;
    logic flt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state, channel 0 = button, 1 = up limit, 2 = down limit.
  logic          m_s1     [3];
  logic          m_s2     [3];
  logic          m_stable [3];
  logic [DB-1:0] m_win    [3];
  int            m_wn     [3];
  logic          m_btn_prev;

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      m_s1[c] = 1'b0;
      m_s2[c] = 1'b0;
      m_stable[c] = 1'b0;
      m_win[c] = '0;
      m_wn[c] = 0;
    end
    m_btn_prev = 1'b0;
  endtask

  // Predict the outputs seen just after the next rising edge, given current inputs.
  // A level is accepted when the last DB synchronized samples all disagree with it.
  task automatic model_step();
    exp_t e;
    logic raw [3];
    logic old_btn, old_up, old_dn;
    e = '0;
    if (!RST_n) begin
      model_clear();
    end else begin
      raw[0] = Btn_raw;
      raw[1] = Up_lim_raw;
      raw[2] = Dn_lim_raw;
      old_btn = m_stable[0];
      old_up  = m_stable[1];
      old_dn  = m_stable[2];
      for (int c = 0; c < 3; c++) begin
        m_win[c] = {m_win[c][DB-2:0], m_s2[c]};
        if (m_wn[c] < DB) m_wn[c]++;
        if (m_wn[c] == DB && m_win[c] == {DB{~m_stable[c]}})
          m_stable[c] = ~m_stable[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
      e.act = old_btn & ~m_btn_prev;
      m_btn_prev = old_btn;
      e.flt = old_up & old_dn;
      e.up  = m_stable[1];
      e.dn  = m_stable[2];
    end
    exp_q.push_back(e);
  endtask

  // Apply one clock's worth of inputs and record what the next edge must produce.
  task automatic cycle(input logic btn, input logic up, input logic dn, input logic rst_n);
    Btn_raw    = btn;
    Up_lim_raw = up;
    Dn_lim_raw = dn;
    RST_n      = rst_n;
    model_step();
    @(negedge CLK);
  endtask

  task automatic repeat_cycle(input int n, input logic btn, input logic up, input logic dn,
                              input logic rst_n);
    for (int i = 0; i < n; i++) cycle(btn, up, dn, rst_n);
  endtask

  // Monitor: compare the DUT against the oldest expectation after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow at %0t: no expectation queued", $time);
      end else begin
        e = exp_q.pop_front();
        if ({Activate, Up_max, Dn_max, Lim_fault} !== e) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t act/up/dn/flt got %b%b%b%b expected %b%b%b%b",
                   vectors, $time, Activate, Up_max, Dn_max, Lim_fault,
                   e.act, e.up, e.dn, e.flt);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized holds and resets.
  initial begin
    int   hold [3];
    logic lvl  [3];
    logic rst_v;
    model_clear();

    // Reset with every raw input high, then release and hold.
    repeat_cycle(3, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat_cycle(12, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat_cycle(10, 1'b0, 1'b0, 1'b0, 1'b1);

    // Clean press held 20 clocks, then release.
    repeat_cycle(20, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat_cycle(10, 1'b0, 1'b0, 1'b0, 1'b1);

    // Three-clock glitch on button and lower limit.
    repeat_cycle(3, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat_cycle(10, 1'b0, 1'b0, 1'b0, 1'b1);

    // Upper limit bouncing every 2 clocks for 10 clocks, then settling high.
    for (int i = 0; i < 10; i++) cycle(1'b0, ((i / 2) % 2) == 0, 1'b0, 1'b1);
    repeat_cycle(12, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat_cycle(10, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a button debounce; button stays high through it.
    repeat_cycle(4, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat_cycle(2, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat_cycle(12, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat_cycle(10, 1'b0, 1'b0, 1'b0, 1'b1);

    // Door closed, then a press: Activate must fire while Dn_max is high.
    repeat_cycle(8, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat_cycle(10, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat_cycle(10, 1'b0, 1'b0, 1'b1, 1'b1);

    // Random levels held 1..8 clocks so both glitches and accepted edges occur.
    for (int c = 0; c < 3; c++) begin
      hold[c] = 0;
      lvl[c]  = 1'b0;
    end
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          lvl[c]  = $urandom_range(0, 1) == 1;
          hold[c] = $urandom_range(1, 8);
        end
        hold[c]--;
      end
      rst_v = ($urandom_range(0, 199) != 0);
      cycle(lvl[0], lvl[1], lvl[2], rst_v);
    end
    repeat_cycle(12, 1'b0, 1'b0, 1'b0, 1'b1);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
